array_heap: RTL and testbench

//  Clocked, handshaked successor to the combinational-decode array memory. Holds ARRAYS fixed blocks of

---
 rtl/array_heap.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_array_heap.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/array_heap.sv
// array_heap: clocked array store with valid/ready requests and a one-cycle response pulse.
// Holds ARRAYS blocks of ARRAY_LENGTH elements, each with a size, and hands out array
// numbers through an allocation counter backed by a free stack.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   req_valid/ready  request handshake; ready only while idle
//   action/array/index/in  request opcode, array number, element index, data
//   resp_valid       one-cycle pulse qualifying out/error
//   out              result, zero-extended where narrower
//   error            0 ok, 1 bad action, 2 full, 3 empty, 4 heap exhausted,
//                    5 unallocated, 6 read past size, 7 double free
// Build option: ARRAY_HEAP_CHECK_EN enables allocation/bounds checks (codes 5-7).
module array_heap #(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned INDEX_BITS   = 3,
  parameter int unsigned DATA_BITS    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4:0]              action,
  input  logic [ADDRESS_BITS-1:0] array,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_BITS-1:0]    in,
  output logic                    resp_valid,
  output logic [DATA_BITS-1:0]    out,
  output logic [7:0]              error
);
  localparam int unsigned ARRAYS       = 2**ADDRESS_BITS;
  localparam int unsigned ARRAY_LENGTH = 2**INDEX_BITS;
  localparam int unsigned SB           = INDEX_BITS + 1;
  localparam int unsigned CB           = ADDRESS_BITS + 1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_EXEC, S_SCAN, S_RESP} state_e;
  typedef enum logic [4:0] {
    A_RESET = 5'd1,  A_WRITE = 5'd2,  A_READ = 5'd3,  A_SIZE = 5'd4,
    A_LESS  = 5'd8,  A_GREATER = 5'd9, A_UP = 5'd10,  A_DOWN = 5'd11,
    A_PUSH  = 5'd14, A_POP = 5'd15,   A_ALLOC = 5'd18, A_FREE = 5'd19
  } action_e;

  state_e state_q, state_d;

  logic [DATA_BITS-1:0]    mem_q    [ARRAYS][ARRAY_LENGTH];
  logic [SB-1:0]           size_q   [ARRAYS];
  logic [ADDRESS_BITS-1:0] fstack_q [ARRAYS];

  logic [4:0]              act_q;
  logic [ADDRESS_BITS-1:0] arr_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [DATA_BITS-1:0]    din_q;

  logic [INDEX_BITS-1:0]   j_q, j_d;
  logic [DATA_BITS-1:0]    carry_q, carry_d;
  logic [SB-1:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0]    hold_q, hold_d;
  logic [ADDRESS_BITS-1:0] clr_q, clr_d;
  logic                    clr_resp_q, clr_resp_d;
  logic [CB-1:0]           top_q, top_d;
  logic [CB-1:0]           count_q, count_d;
  logic [DATA_BITS-1:0]    out_q, out_d;
  logic [7:0]              err_q, err_d;

  logic                    ld;
  logic                    mem_we;
  logic [INDEX_BITS-1:0]   mem_wi;
  logic [DATA_BITS-1:0]    mem_wd;
  logic                    size_we;
  logic [ADDRESS_BITS-1:0] size_wa;
  logic [SB-1:0]           size_wd;
  logic                    fs_we;

`ifdef ARRAY_HEAP_CHECK_EN
  logic                    alloc_q [ARRAYS];
  logic                    alloc_we;
  logic [ADDRESS_BITS-1:0] alloc_wa;
  logic                    alloc_wd;
`endif

  logic [SB-1:0]           cur_size;
  logic [SB-1:0]           idx_ext;
  logic [SB-1:0]           j_ext;
  logic [INDEX_BITS-1:0]   j_nx;
  logic [INDEX_BITS-1:0]   last_i;
  logic [DATA_BITS-1:0]    elem_j;
  logic [DATA_BITS-1:0]    elem_j1;
  logic [ADDRESS_BITS-1:0] new_arr;
  logic                    exhausted;
  logic                    known;
  logic [7:0]              chk_err;
  logic [7:0]              err;

  always_comb begin
    cur_size  = size_q[arr_q];
    idx_ext   = {1'b0, idx_q};
    j_ext     = {1'b0, j_q};
    j_nx      = j_q + 1'b1;
    last_i    = INDEX_BITS'(cur_size - 1'b1);
    elem_j    = mem_q[arr_q][j_q];
    elem_j1   = mem_q[arr_q][j_nx];
    new_arr   = (top_q != '0) ? fstack_q[ADDRESS_BITS'(top_q - 1'b1)]
                              : count_q[ADDRESS_BITS-1:0];
    exhausted = (top_q == '0) && (count_q == CB'(ARRAYS));
    known     = act_q inside {A_RESET, A_WRITE, A_READ, A_SIZE, A_LESS, A_GREATER,
                              A_UP, A_DOWN, A_PUSH, A_POP, A_ALLOC, A_FREE};
    chk_err   = '0;
`ifdef ARRAY_HEAP_CHECK_EN
    if (act_q != A_RESET && act_q != A_ALLOC) begin
      if (!alloc_q[arr_q])
        chk_err = (act_q == A_FREE) ? 8'd7 : 8'd5;
      else if (act_q == A_READ && idx_ext >= cur_size)
        chk_err = 8'd6;
    end
`endif
    err = '0;
    if (!known) err = 8'd1;
    else if (chk_err != '0) err = chk_err;
    else begin
      case (act_q)
        A_UP, A_PUSH:  if (cur_size == SB'(ARRAY_LENGTH)) err = 8'd2;
        A_DOWN, A_POP: if (cur_size == '0) err = 8'd3;
        A_ALLOC:       if (exhausted) err = 8'd4;
        default:       ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    ld         = 1'b0;
    mem_we     = 1'b0;
    mem_wi     = j_q;
    mem_wd     = din_q;
    size_we    = 1'b0;
    size_wa    = arr_q;
    size_wd    = cur_size;
    fs_we      = 1'b0;
`ifdef ARRAY_HEAP_CHECK_EN
    alloc_we   = 1'b0;
    alloc_wa   = arr_q;
    alloc_wd   = 1'b0;
`endif
    top_d      = top_q;
    count_d    = count_q;
    out_d      = out_q;
    err_d      = err_q;
    j_d        = j_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    clr_d      = clr_q;
    clr_resp_d = clr_resp_q;

    case (state_q)
      S_CLEAR: begin
        size_we = 1'b1;
        size_wa = clr_q;
        size_wd = '0;
`ifdef ARRAY_HEAP_CHECK_EN
        alloc_we = 1'b1;
        alloc_wa = clr_q;
`endif
        clr_d = clr_q + 1'b1;
        if (clr_q == '1) begin
          clr_resp_d = 1'b0;
          out_d      = '0;
          err_d      = '0;
          state_d    = clr_resp_q ? S_RESP : S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ld = 1'b1;
          case (action)
            A_RESET: begin
              state_d    = S_CLEAR;
              clr_d      = '0;
              clr_resp_d = 1'b1;
              top_d      = '0;
              count_d    = '0;
            end
            A_LESS, A_GREATER, A_UP, A_DOWN: begin
              state_d = S_SCAN;
              j_d     = '0;
              cnt_d   = '0;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end
      // One element per cycle in ascending order. Up carries the displaced element
      // forward; Down reads j+1 before it is overwritten on the following cycle.
      S_SCAN: begin
        j_d = j_nx;
        if (j_q == '1) state_d = S_EXEC;
        if (err == '0) begin
          case (act_q)
            A_LESS:    if (j_ext < cur_size && elem_j < din_q) cnt_d = cnt_q + 1'b1;
            A_GREATER: if (j_ext < cur_size && elem_j > din_q) cnt_d = cnt_q + 1'b1;
            A_UP: begin
              if (j_q == idx_q) begin
                carry_d = elem_j;
                mem_we  = 1'b1;
                mem_wd  = din_q;
              end else if (j_q > idx_q && j_ext <= cur_size) begin
                carry_d = elem_j;
                mem_we  = 1'b1;
                mem_wd  = carry_q;
              end
            end
            A_DOWN: begin
              if (j_q == idx_q) hold_d = elem_j;
              if (j_q >= idx_q && (j_ext + 1'b1) < cur_size) begin
                mem_we = 1'b1;
                mem_wd = elem_j1;
              end
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (err != '0) begin
          out_d = '0;
          err_d = err;
        end else begin
          err_d = '0;
          case (act_q)
            A_WRITE: begin
              mem_we = 1'b1;
              mem_wi = idx_q;
              if (idx_ext >= cur_size) begin
                size_we = 1'b1;
                size_wd = idx_ext + 1'b1;
              end
              out_d = din_q;
            end
            A_READ:            out_d = mem_q[arr_q][idx_q];
            A_SIZE:            out_d = DATA_BITS'(cur_size);
            A_LESS, A_GREATER: out_d = DATA_BITS'(cnt_q);
            A_UP: begin
              size_we = 1'b1;
              size_wd = cur_size + 1'b1;
              out_d   = din_q;
            end
            A_DOWN: begin
              size_we = 1'b1;
              size_wd = cur_size - 1'b1;
              out_d   = hold_q;
            end
            A_PUSH: begin
              mem_we  = 1'b1;
              mem_wi  = cur_size[INDEX_BITS-1:0];
              size_we = 1'b1;
              size_wd = cur_size + 1'b1;
              out_d   = din_q;
            end
            A_POP: begin
              size_we = 1'b1;
              size_wd = cur_size - 1'b1;
              out_d   = mem_q[arr_q][last_i];
            end
            A_ALLOC: begin
              size_we = 1'b1;
              size_wa = new_arr;
              size_wd = '0;
`ifdef ARRAY_HEAP_CHECK_EN
              alloc_we = 1'b1;
              alloc_wa = new_arr;
              alloc_wd = 1'b1;
`endif
              if (top_q != '0) top_d = top_q - 1'b1;
              else             count_d = count_q + 1'b1;
              out_d = DATA_BITS'(new_arr);
            end
            A_FREE: begin
              fs_we = 1'b1;
              top_d = top_q + 1'b1;
`ifdef ARRAY_HEAP_CHECK_EN
              alloc_we = 1'b1;
`endif
              out_d = DATA_BITS'(arr_q);
            end
            default: ;
          endcase
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_q      <= '0;
      clr_resp_q <= 1'b0;
      top_q      <= '0;
      count_q    <= '0;
      out_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      clr_resp_q <= clr_resp_d;
      top_q      <= top_d;
      count_q    <= count_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ld) begin
      act_q <= action;
      arr_q <= array;
      idx_q <= index;
      din_q <= in;
    end
    j_q     <= j_d;
    carry_q <= carry_d;
    cnt_q   <= cnt_d;
    hold_q  <= hold_d;
    if (mem_we)  mem_q[arr_q][mem_wi] <= mem_wd;
    if (size_we) size_q[size_wa] <= size_wd;
    if (fs_we)   fstack_q[top_q[ADDRESS_BITS-1:0]] <= arr_q;
  end

`ifdef ARRAY_HEAP_CHECK_EN
  always_ff @(posedge clock) begin
    if (alloc_we) alloc_q[alloc_wa] <= alloc_wd;
  end
`endif

  assign resp_valid = (state_q == S_RESP);
  assign out        = out_q;
  assign error      = resp_valid ? err_q : '0;

endmodule

// File: tb/tb_array_heap.sv
// Directed bench for array_heap at default parameters (8/3/16).
module tb_array_heap;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  action;
  logic [7:0]  array;
  logic [2:0]  index;
  logic [15:0] in;
  logic        resp_valid;
  logic [15:0] out;
  logic [7:0]  error;

  int checks = 0;
  int failures = 0;

  array_heap #(.ADDRESS_BITS(8), .INDEX_BITS(3), .DATA_BITS(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .action(action), .array(array), .index(index), .in(in),
    .resp_valid(resp_valid), .out(out), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where resp_valid was seen.
  task automatic op(input string tag, input logic [4:0] a, input logic [7:0] ar,
                    input logic [2:0] ix, input logic [15:0] d,
                    input logic [15:0] exp_o, input logic [7:0] exp_e, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    action = a; array = ar; index = ix; in = d; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    action = 5'd0; in = 16'hDEAD;
    lat = 1;
    while (!resp_valid && lat < 400) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_out"}, {16'd0, out}, {16'd0, exp_o});
    chk({tag, "_err"}, {24'd0, error}, {24'd0, exp_e});
  endtask

  task automatic wait_clear(input string tag, output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (!req_ready && n < 1000) begin
      if (resp_valid) pulses++;
      n++;
      @(negedge clock);
    end
    chk({tag, "_len"}, n, 256);
  endtask

  initial begin : main
    int n;
    int pulses;
    logic [15:0] exp3 [7];
    logic [15:0] exp4 [4];
    exp3 = '{16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    exp4 = '{16'd10, 16'd15, 16'd20, 16'd30};
    reset = 1'b1; req_valid = 1'b0; action = '0; array = '0; index = '0; in = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // 1. reset state, clear length, first allocations
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_err", {24'd0, error}, 32'd0);
    wait_clear("clear", n, pulses);
    op("alloc0", 5'd18, 8'd0, 3'd0, 16'd0, 16'd0, 8'd0, 2);
    op("alloc1", 5'd18, 8'd0, 3'd0, 16'd0, 16'd1, 8'd0, 2);

    // 2. push/pop on a0
    op("push5", 5'd14, 8'd0, 3'd0, 16'd5, 16'd5, 8'd0, 2);
    op("push7", 5'd14, 8'd0, 3'd0, 16'd7, 16'd7, 8'd0, 2);
    op("push9", 5'd14, 8'd0, 3'd0, 16'd9, 16'd9, 8'd0, 2);
    op("size3", 5'd4, 8'd0, 3'd0, 16'd0, 16'd3, 8'd0, 2);
    op("pop9", 5'd15, 8'd0, 3'd0, 16'd0, 16'd9, 8'd0, 2);
    op("pop7", 5'd15, 8'd0, 3'd0, 16'd0, 16'd7, 8'd0, 2);
    op("pop5", 5'd15, 8'd0, 3'd0, 16'd0, 16'd5, 8'd0, 2);
    op("pop_empty", 5'd15, 8'd0, 3'd0, 16'd0, 16'd0, 8'd3, 2);
    op("size0", 5'd4, 8'd0, 3'd0, 16'd0, 16'd0, 8'd0, 2);

    // 3. fill, overflow, Up on full, Down from middle
    for (int i = 1; i <= 8; i++)
      op($sformatf("fill%0d", i), 5'd14, 8'd0, 3'd0, 16'(i), 16'(i), 8'd0, 2);
    op("push_full", 5'd14, 8'd0, 3'd0, 16'd9, 16'd0, 8'd2, 2);
    op("up_full", 5'd10, 8'd0, 3'd0, 16'd4, 16'd0, 8'd2, 10);
    op("down2", 5'd11, 8'd0, 3'd2, 16'd0, 16'd3, 8'd0, 10);
    for (int i = 0; i < 7; i++)
      op($sformatf("rd3_%0d", i), 5'd3, 8'd0, 3'(i), 16'd0, exp3[i], 8'd0, 2);
    op("size7", 5'd4, 8'd0, 3'd0, 16'd0, 16'd7, 8'd0, 2);
    op("write7", 5'd2, 8'd0, 3'd7, 16'h1234, 16'h1234, 8'd0, 2);
    op("size8", 5'd4, 8'd0, 3'd0, 16'd0, 16'd8, 8'd0, 2);
    op("read7", 5'd3, 8'd0, 3'd7, 16'd0, 16'h1234, 8'd0, 2);

    // 4. insert and compare counts on a1
    op("p10", 5'd14, 8'd1, 3'd0, 16'd10, 16'd10, 8'd0, 2);
    op("p20", 5'd14, 8'd1, 3'd0, 16'd20, 16'd20, 8'd0, 2);
    op("p30", 5'd14, 8'd1, 3'd0, 16'd30, 16'd30, 8'd0, 2);
    op("up15", 5'd10, 8'd1, 3'd1, 16'd15, 16'd15, 8'd0, 10);
    for (int i = 0; i < 4; i++)
      op($sformatf("rd4_%0d", i), 5'd3, 8'd1, 3'(i), 16'd0, exp4[i], 8'd0, 2);
    op("size4", 5'd4, 8'd1, 3'd0, 16'd0, 16'd4, 8'd0, 2);
    op("greater15", 5'd9, 8'd1, 3'd0, 16'd15, 16'd2, 8'd0, 10);
    op("less15", 5'd8, 8'd1, 3'd0, 16'd15, 16'd1, 8'd0, 10);

    // 5. free/reuse and access checks
`ifdef ARRAY_HEAP_CHECK_EN
    op("read_oob", 5'd3, 8'd1, 3'd5, 16'd0, 16'd0, 8'd6, 2);
    op("write_unalloc", 5'd2, 8'd9, 3'd0, 16'd1, 16'd0, 8'd5, 2);
`endif
    op("free1", 5'd19, 8'd1, 3'd0, 16'd0, 16'd1, 8'd0, 2);
    op("realloc1", 5'd18, 8'd0, 3'd0, 16'd0, 16'd1, 8'd0, 2);
`ifdef ARRAY_HEAP_CHECK_EN
    op("free1b", 5'd19, 8'd1, 3'd0, 16'd0, 16'd1, 8'd0, 2);
    op("double_free", 5'd19, 8'd1, 3'd0, 16'd0, 16'd0, 8'd7, 2);
`endif

    // 6. Reset action, reset during scan, unknown action
    op("act_reset", 5'd1, 8'd0, 3'd0, 16'd0, 16'd0, 8'd0, 257);
    op("alloc_after", 5'd18, 8'd0, 3'd0, 16'd0, 16'd0, 8'd0, 2);
    op("push55", 5'd14, 8'd0, 3'd0, 16'h55, 16'h55, 8'd0, 2);
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    action = 5'd10; array = 8'd0; index = 3'd0; in = 16'd4; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_clear("midreset", n, pulses);
    chk("midreset_noresp", pulses, 0);
`ifdef ARRAY_HEAP_CHECK_EN
    op("size_after", 5'd4, 8'd0, 3'd0, 16'd0, 16'd0, 8'd5, 2);
`else
    op("size_after", 5'd4, 8'd0, 3'd0, 16'd0, 16'd0, 8'd0, 2);
`endif
    op("bad_action", 5'd31, 8'd0, 3'd0, 16'd7, 16'd0, 8'd1, 2);
    @(negedge clock);
    chk("err_cleared", {24'd0, error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
